// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module      : seq_alu_pkg
// Description : Opcodes, FSM state encoding and sizing helper for seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter must hold WIDTH itself (the MUL step count).
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_comb.sv
// ============================================================================
// Module      : seq_alu_comb
// Description : Single-cycle ALU operations and flags; MUL/shift opcodes pass
//               operand A through (the zero-length shift result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_comb
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP_W  = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             carry_o,
    output logic             illegal_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] sub_sum;
    logic [WIDTH-1:0] res;

    assign add_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sub_sum = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res        = '0;
        overflow_o = 1'b0;
        carry_o    = 1'b0;
        illegal_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                res        = add_sum[WIDTH-1:0];
                carry_o    = add_sum[WIDTH];
                overflow_o = (a_i[MSB] == b_i[MSB]) && (add_sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                res        = sub_sum[WIDTH-1:0];
                carry_o    = sub_sum[WIDTH];
                overflow_o = (a_i[MSB] != b_i[MSB]) && (sub_sum[MSB] != a_i[MSB]);
            end
            OP_NOT: res = ~a_i;
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_EQ:  res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            OP_MUL, OP_SLL, OP_SRL, OP_SRA: res = a_i;
            default: illegal_o = 1'b1;
        endcase
    end

    assign result_o = res;
    assign zero_o   = ~|res;

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Handshaked ALU; single-cycle ops via seq_alu_comb, iterative
//               shift-add MUL and one-bit-per-cycle shifts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             illegal
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = cnt_w(WIDTH);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               shc_q, shc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               carry_q, carry_d;
    logic               ill_q, ill_d;

    logic [WIDTH-1:0]   c_res;
    logic               c_zero, c_ovf, c_carry, c_ill;

    logic               accept, is_mul, is_shift, multi, last_step;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH:0]     prod_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   sh_step;
    logic               shc_step;

    seq_alu_comb #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_comb (
        .a_i        (data_a),
        .b_i        (data_b),
        .op_i       (op),
        .result_o   (c_res),
        .zero_o     (c_zero),
        .overflow_o (c_ovf),
        .carry_o    (c_carry),
        .illegal_o  (c_ill)
    );

    assign accept    = in_valid && (state_q == IDLE);
    assign shamt     = data_b[SH_W-1:0];
    assign is_mul    = (op == OP_MUL);
    assign is_shift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign multi     = is_mul || (is_shift && (shamt != '0));
    assign last_step = (state_q == BUSY) && (cnt_q == CNT_W'(1));

    // Shift-add: add A into the high half when the multiplier LSB is set, then shift right.
    assign prod_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                     + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign prod_step = {prod_sum, prod_q[WIDTH-1:1]};

    always_comb begin
        sh_step  = sh_q;
        shc_step = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_step  = {sh_q[WIDTH-2:0], 1'b0};
                shc_step = sh_q[WIDTH-1];
            end
            OP_SRL: begin
                sh_step  = {1'b0, sh_q[WIDTH-1:1]};
                shc_step = sh_q[0];
            end
            OP_SRA: begin
                sh_step  = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                shc_step = sh_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = multi ? BUSY : DONE;
            BUSY:    if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        sh_d    = sh_q;
        shc_d   = shc_q;
        res_d   = res_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        carry_d = carry_q;
        ill_d   = ill_q;
        if (accept) begin
            a_d    = data_a;
            op_d   = op;
            cnt_d  = is_mul ? CNT_W'(WIDTH) : {1'b0, shamt};
            prod_d = {{WIDTH{1'b0}}, data_b};
            sh_d   = data_a;
            shc_d  = 1'b0;
            if (!multi) begin
                res_d   = c_res;
                hi_d    = '0;
                zero_d  = c_zero;
                ovf_d   = c_ovf;
                carry_d = c_carry;
                ill_d   = c_ill;
            end
        end else if (state_q == BUSY) begin
            cnt_d  = cnt_q - CNT_W'(1);
            prod_d = prod_step;
            sh_d   = sh_step;
            shc_d  = shc_step;
            if (last_step) begin
                ill_d = 1'b0;
                if (op_q == OP_MUL) begin
                    res_d   = prod_step[WIDTH-1:0];
                    hi_d    = prod_step[2*WIDTH-1:WIDTH];
                    zero_d  = ~|prod_step[WIDTH-1:0];
                    ovf_d   = |prod_step[2*WIDTH-1:WIDTH];
                    carry_d = 1'b0;
                end else begin
                    res_d   = sh_step;
                    hi_d    = '0;
                    zero_d  = ~|sh_step;
                    ovf_d   = 1'b0;
                    carry_d = shc_step;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            sh_q    <= '0;
            shc_q   <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            sh_q    <= sh_d;
            shc_q   <= shc_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            ill_q   <= ill_d;
        end
    end

    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry     = carry_q;
    assign illegal   = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed self-checking bench for seq_alu at WIDTH = 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;
    import seq_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] data_a = 4'h0;
    logic [3:0] data_b = 4'h0;
    logic [3:0] op = 4'h0;
    logic       in_ready, out_valid, zero, overflow, carry, illegal;
    logic [3:0] result, result_hi;
    logic [11:0] obs;

    int total = 0;
    int bad   = 0;
    int lat;

    // Packed view: {result_hi, result, zero, overflow, carry, illegal}
    assign obs = {result_hi, result, zero, overflow, carry, illegal};

    seq_alu #(.WIDTH(4), .OP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow),
        .carry     (carry),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Present one operation, return 1 ns after its acceptance edge with inputs scrambled.
    task automatic issue(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] ov);
        @(negedge clk);
        data_a   = av;
        data_b   = bv;
        op       = ov;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_a   = ~av;
        data_b   = ~bv;
        op       = ov ^ 4'h3;
    endtask

    task automatic wait_done(input int max, output int l);
        int i = 0;
        l = -1;
        while (l < 0 && i < max) begin
            @(negedge clk);
            i++;
            if (out_valid) l = i;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== 12'h008) begin
            bad++;
            $display("FAIL reset got rdy=%b vld=%b obs=%h exp rdy=1 vld=0 obs=008", in_ready, out_valid, obs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add();
        issue(4'h7, 4'h9, OP_ADD);
        wait_done(8, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
        total++;
        if (obs !== 12'h00A) begin bad++; $display("FAIL add_7_9 got=%h exp=00a", obs); end
        consume();
        issue(4'h7, 4'h1, OP_ADD);
        wait_done(8, lat);
        total++;
        if (obs !== 12'h084) begin bad++; $display("FAIL add_7_1 got=%h exp=084", obs); end
        consume();
    endtask

    task automatic test_sub_illegal();
        issue(4'h4, 4'h5, OP_SUB);
        wait_done(8, lat);
        total++;
        if (obs !== 12'h0F0) begin bad++; $display("FAIL sub_4_5 got=%h exp=0f0", obs); end
        consume();
        issue(4'h6, 4'h2, 4'd13);
        wait_done(8, lat);
        total++;
        if (lat !== 1 || obs !== 12'h009) begin
            bad++;
            $display("FAIL illegal got lat=%0d obs=%h exp lat=1 obs=009", lat, obs);
        end
        consume();
    endtask

    task automatic test_mul();
        issue(4'hF, 4'hF, OP_MUL);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== (i == 5)) begin
                bad++;
                $display("FAIL mul_timing cyc=%0d got rdy=%b vld=%b exp rdy=0 vld=%b", i, in_ready, out_valid, (i == 5));
            end
        end
        total++;
        if (obs !== 12'hE14) begin bad++; $display("FAIL mul_f_f got=%h exp=e14", obs); end
        consume();
    endtask

    task automatic test_shift();
        issue(4'hB, 4'h2, OP_SRL);
        wait_done(8, lat);
        total++;
        if (lat !== 3 || obs !== 12'h022) begin
            bad++;
            $display("FAIL srl_b_2 got lat=%0d obs=%h exp lat=3 obs=022", lat, obs);
        end
        consume();
        issue(4'h8, 4'h3, OP_SRA);
        wait_done(8, lat);
        total++;
        if (lat !== 4 || obs !== 12'h0F0) begin
            bad++;
            $display("FAIL sra_8_3 got lat=%0d obs=%h exp lat=4 obs=0f0", lat, obs);
        end
        consume();
        issue(4'h5, 4'h0, OP_SLL);
        wait_done(8, lat);
        total++;
        if (lat !== 1 || obs !== 12'h050) begin
            bad++;
            $display("FAIL sll_5_0 got lat=%0d obs=%h exp lat=1 obs=050", lat, obs);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        issue(4'h5, 4'h3, OP_XOR);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || obs !== 12'h060) begin
            bad++;
            $display("FAIL b2b_xor got vld=%b obs=%h exp vld=1 obs=060", out_valid, obs);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_len got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        end
        issue(4'h1, 4'hF, OP_SLT);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || obs !== 12'h008) begin
            bad++;
            $display("FAIL b2b_slt got vld=%b obs=%h exp vld=1 obs=008", out_valid, obs);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        issue(4'hC, 4'hA, OP_AND);
        wait_done(8, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            data_a   = 4'h3;
            data_b   = 4'h3;
            op       = OP_ADD;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== 12'h080) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b obs=%h exp vld=1 rdy=0 obs=080", i, out_valid, in_ready, obs);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== 12'h080) begin
            bad++;
            $display("FAIL bp_release got rdy=%b vld=%b obs=%h exp rdy=1 vld=0 obs=080", in_ready, out_valid, obs);
        end
    endtask

    task automatic test_reset_mid();
        issue(4'h3, 4'h3, OP_MUL);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== 12'h008) begin
            bad++;
            $display("FAIL rst_mid got rdy=%b vld=%b obs=%h exp rdy=1 vld=0 obs=008", in_ready, out_valid, obs);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_drop got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        end
        issue(4'h6, 4'h6, OP_EQ);
        wait_done(8, lat);
        total++;
        if (lat !== 1 || obs !== 12'h010) begin
            bad++;
            $display("FAIL eq_6_6 got lat=%0d obs=%h exp lat=1 obs=010", lat, obs);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_illegal();
        test_mul();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
